// File: rtl/id_stage_ctrl.sv
// IF/ID pipeline register with immediate-source decode and an illegal-opcode trap FSM.
// A trapping instruction is bubbled on entry so it can never raise a second trap.
module id_stage_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCF,
    input  logic        ValidF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        TrapAck,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic        ValidD,
    output logic [24:0] ImmFieldD,
    output logic [1:0]  ImmSrcD,
    output logic        UTypeD,
    output logic        IllegalD,
    output logic        TrapReq,
    output logic [7:0]  IllegalCnt
);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t state;
    state_t nextState;
    logic   trapEntry;

    assign trapEntry = (state == RUN) && IllegalD && !FlushD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            RUN:     if (trapEntry) nextState = TRAP;
            TRAP:    if (TrapAck) nextState = RUN;
            default: nextState = RUN;
        endcase
    end

    always_comb begin
        TrapReq = (state == TRAP);
    end

    // Bubble on trap entry as well as while trapped, so the offending instruction leaves D.
    always_ff @(posedge clk) begin
        if (rst || (state == TRAP) || FlushD || trapEntry) begin
            InstrD <= NOP_INSTR;
            PCD    <= 32'h0;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            InstrD <= InstrF;
            PCD    <= PCF;
            ValidD <= ValidF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            IllegalCnt <= 8'h00;
        end else if (trapEntry && (IllegalCnt != 8'hFF)) begin
            IllegalCnt <= IllegalCnt + 8'h01;
        end
    end

    assign ImmFieldD = InstrD[31:7];

    // LUI/AUIPC build their immediate outside the extender, so ImmSrcD is a don't-care there.
    always_comb begin
        ImmSrcD  = 2'd0;
        UTypeD   = 1'b0;
        IllegalD = 1'b0;
        case (InstrD[6:0])
            7'b0000011,
            7'b0010011,
            7'b1100111: ImmSrcD = 2'd0;
            7'b0100011: ImmSrcD = 2'd1;
            7'b1100011: ImmSrcD = 2'd2;
            7'b1101111: ImmSrcD = 2'd3;
            7'b0110011: ImmSrcD = 2'd0;
            7'b0110111,
            7'b0010111: UTypeD = 1'b1;
            default:    IllegalD = ValidD;
        endcase
    end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: capture/decode, stall/flush, trap handshake,
// flush suppression of traps, counter saturation and reset during a trap.
module tb_id_stage_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        ValidF;
    logic        StallD;
    logic        FlushD;
    logic        TrapAck;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic        ValidD;
    logic [24:0] ImmFieldD;
    logic [1:0]  ImmSrcD;
    logic        UTypeD;
    logic        IllegalD;
    logic        TrapReq;
    logic [7:0]  IllegalCnt;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    id_stage_ctrl #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF),
        .StallD(StallD), .FlushD(FlushD), .TrapAck(TrapAck),
        .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD), .ImmFieldD(ImmFieldD),
        .ImmSrcD(ImmSrcD), .UTypeD(UTypeD), .IllegalD(IllegalD),
        .TrapReq(TrapReq), .IllegalCnt(IllegalCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; StallD = 1'b1; FlushD = 1'b1; TrapAck = 1'b1;
        InstrF = 32'h0000007F; PCF = 32'h44; ValidF = 1'b1;
        tick();
        tick();
        total++; if (InstrD !== NOP) begin bad++; $display("[TB] FAIL reset_instr: got %h want %h", InstrD, NOP); end
        total++; if (PCD !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h want 0", PCD); end
        total++; if (ValidD !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", ValidD); end
        total++; if (TrapReq !== 1'b0) begin bad++; $display("[TB] FAIL reset_trapreq: got %b want 0", TrapReq); end
        total++; if (IllegalCnt !== 8'h00) begin bad++; $display("[TB] FAIL reset_cnt: got %h want 00", IllegalCnt); end
        total++; if ({ImmSrcD, UTypeD, IllegalD} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_decode: got %b want 0000", {ImmSrcD, UTypeD, IllegalD}); end
        rst = 1'b0; StallD = 1'b0; FlushD = 1'b0; TrapAck = 1'b0; ValidF = 1'b0;
    endtask

    task automatic test_capture();
        logic [31:0] instrs [6] = '{32'h00A00513, 32'hFE112E23, 32'h00000463,
                                    32'h0080006F, 32'h000002B7, 32'h00B50533};
        logic [1:0]  expSrc [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        logic        expU   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            logic [31:0] w;
            logic [31:0] pc;
            w  = instrs[i];
            pc = 32'h100 + 32'(4 * i);
            InstrF = w; PCF = pc; ValidF = 1'b1;
            tick();
            total++; if (InstrD !== w) begin bad++; $display("[TB] FAIL cap_instr[%0d]: got %h want %h", i, InstrD, w); end
            total++; if (PCD !== pc) begin bad++; $display("[TB] FAIL cap_pc[%0d]: got %h want %h", i, PCD, pc); end
            total++; if (ValidD !== 1'b1) begin bad++; $display("[TB] FAIL cap_valid[%0d]: got %b want 1", i, ValidD); end
            total++; if (ImmSrcD !== expSrc[i]) begin bad++; $display("[TB] FAIL cap_immsrc[%0d]: got %0d want %0d", i, ImmSrcD, expSrc[i]); end
            total++; if (UTypeD !== expU[i]) begin bad++; $display("[TB] FAIL cap_utype[%0d]: got %b want %b", i, UTypeD, expU[i]); end
            total++; if (IllegalD !== 1'b0) begin bad++; $display("[TB] FAIL cap_illegal[%0d]: got %b want 0", i, IllegalD); end
            total++; if (ImmFieldD !== w[31:7]) begin bad++; $display("[TB] FAIL cap_immfield[%0d]: got %h want %h", i, ImmFieldD, w[31:7]); end
        end
        ValidF = 1'b0;
        tick();
        total++; if (ValidD !== 1'b0) begin bad++; $display("[TB] FAIL cap_validf0: got %b want 0", ValidD); end
    endtask

    task automatic test_stall_flush();
        InstrF = 32'h00A00513; PCF = 32'h300; ValidF = 1'b1;
        tick();
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            InstrF = 32'h00100093 + 32'(i); PCF = 32'h400 + 32'(4 * i);
            tick();
            total++; if (InstrD !== 32'h00A00513) begin bad++; $display("[TB] FAIL stall_instr[%0d]: got %h want 00a00513", i, InstrD); end
            total++; if (PCD !== 32'h300) begin bad++; $display("[TB] FAIL stall_pc[%0d]: got %h want 300", i, PCD); end
        end
        FlushD = 1'b1;
        tick();
        total++; if (InstrD !== NOP) begin bad++; $display("[TB] FAIL flush_instr: got %h want %h", InstrD, NOP); end
        total++; if (ValidD !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b want 0", ValidD); end
        total++; if (PCD !== 32'h0) begin bad++; $display("[TB] FAIL flush_pc: got %h want 0", PCD); end
        StallD = 1'b0; FlushD = 1'b0; ValidF = 1'b0;
        tick();
    endtask

    task automatic test_trap();
        InstrF = 32'h0000007F; PCF = 32'h200; ValidF = 1'b1;
        tick();
        total++; if (IllegalD !== 1'b1) begin bad++; $display("[TB] FAIL trap_illegal: got %b want 1", IllegalD); end
        total++; if (TrapReq !== 1'b0) begin bad++; $display("[TB] FAIL trap_req_early: got %b want 0", TrapReq); end
        InstrF = 32'h00A00513; PCF = 32'h204; StallD = 1'b1;
        tick();
        total++; if (TrapReq !== 1'b1) begin bad++; $display("[TB] FAIL trap_req: got %b want 1", TrapReq); end
        total++; if (IllegalCnt !== 8'd1) begin bad++; $display("[TB] FAIL trap_cnt: got %0d want 1", IllegalCnt); end
        total++; if (ValidD !== 1'b0) begin bad++; $display("[TB] FAIL trap_valid: got %b want 0", ValidD); end
        total++; if (IllegalD !== 1'b0) begin bad++; $display("[TB] FAIL trap_illegal_cleared: got %b want 0", IllegalD); end
        for (int i = 0; i < 4; i++) begin
            StallD = i[0]; FlushD = i[1];
            tick();
            total++; if (TrapReq !== 1'b1 || ValidD !== 1'b0 || IllegalCnt !== 8'd1) begin
                bad++; $display("[TB] FAIL trap_hold[%0d]: got req=%b valid=%b cnt=%0d want 1 0 1", i, TrapReq, ValidD, IllegalCnt);
            end
        end
        StallD = 1'b0; FlushD = 1'b0; TrapAck = 1'b1;
        tick();
        total++; if (TrapReq !== 1'b0) begin bad++; $display("[TB] FAIL ack_req: got %b want 0", TrapReq); end
        total++; if (ValidD !== 1'b0) begin bad++; $display("[TB] FAIL ack_valid: got %b want 0", ValidD); end
        TrapAck = 1'b1;
        tick();
        total++; if (InstrD !== 32'h00A00513 || PCD !== 32'h204 || ValidD !== 1'b1) begin
            bad++; $display("[TB] FAIL resume: got %h/%h/%b want 00a00513/204/1", InstrD, PCD, ValidD);
        end
        total++; if (TrapReq !== 1'b0) begin bad++; $display("[TB] FAIL ack_in_run: got %b want 0", TrapReq); end
        TrapAck = 1'b0; ValidF = 1'b0;
        tick();
    endtask

    task automatic test_flush_suppress();
        InstrF = 32'h0000007F; PCF = 32'h500; ValidF = 1'b0;
        tick();
        total++; if (IllegalD !== 1'b0) begin bad++; $display("[TB] FAIL illegal_invalid: got %b want 0", IllegalD); end
        ValidF = 1'b1;
        tick();
        total++; if (IllegalD !== 1'b1) begin bad++; $display("[TB] FAIL sup_illegal: got %b want 1", IllegalD); end
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0; ValidF = 1'b0;
        total++; if (TrapReq !== 1'b0) begin bad++; $display("[TB] FAIL sup_req: got %b want 0", TrapReq); end
        total++; if (IllegalCnt !== 8'd1) begin bad++; $display("[TB] FAIL sup_cnt: got %0d want 1", IllegalCnt); end
        tick();
        total++; if (TrapReq !== 1'b0) begin bad++; $display("[TB] FAIL sup_req_late: got %b want 0", TrapReq); end
    endtask

    task automatic test_saturation();
        logic [7:0] expCnt;
        expCnt = 8'd1;
        for (int i = 0; i < 260; i++) begin
            InstrF = 32'h0000007F; ValidF = 1'b1;
            tick();
            ValidF = 1'b0;
            tick();
            if (expCnt != 8'hFF) expCnt = expCnt + 8'd1;
            TrapAck = 1'b1;
            tick();
            TrapAck = 1'b0;
            total++; if (IllegalCnt !== expCnt) begin bad++; $display("[TB] FAIL sat_cnt[%0d]: got %h want %h", i, IllegalCnt, expCnt); end
        end
        total++; if (IllegalCnt !== 8'hFF) begin bad++; $display("[TB] FAIL sat_final: got %h want ff", IllegalCnt); end
    endtask

    task automatic test_reset_mid_trap();
        InstrF = 32'h0000007F; PCF = 32'h600; ValidF = 1'b1;
        tick();
        ValidF = 1'b0;
        tick();
        total++; if (TrapReq !== 1'b1) begin bad++; $display("[TB] FAIL mid_req_pre: got %b want 1", TrapReq); end
        rst = 1'b1; StallD = 1'b1;
        tick();
        rst = 1'b0; StallD = 1'b0;
        total++; if (TrapReq !== 1'b0) begin bad++; $display("[TB] FAIL mid_req: got %b want 0", TrapReq); end
        total++; if (IllegalCnt !== 8'h00) begin bad++; $display("[TB] FAIL mid_cnt: got %h want 00", IllegalCnt); end
        total++; if (ValidD !== 1'b0 || InstrD !== NOP) begin bad++; $display("[TB] FAIL mid_reg: got %b/%h want 0/%h", ValidD, InstrD, NOP); end
        InstrF = 32'hFE112E23; PCF = 32'h700; ValidF = 1'b1;
        tick();
        total++; if (InstrD !== 32'hFE112E23 || ValidD !== 1'b1) begin bad++; $display("[TB] FAIL mid_run: got %h/%b want fe112e23/1", InstrD, ValidD); end
        ValidF = 1'b0;
    endtask

    initial begin
        rst = 1'b1; InstrF = NOP; PCF = 32'h0; ValidF = 1'b0;
        StallD = 1'b0; FlushD = 1'b0; TrapAck = 1'b0;
        test_reset();
        test_capture();
        test_stall_flush();
        test_trap();
        test_flush_suppress();
        test_saturation();
        test_reset_mid_trap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
